pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register that generalises the fixed per-stage latches (IF/ID, ID/EX, EX/M, M/WB) into a single block with a valid/ready handshake, flush-to-bubble, and an optional two-entry skid buffer. Each stage boundary of the five-stage processor instantiates one copy with its own control and data widths. Back-pressure from cache misses propagates through `out_ready`/`in_ready` rather than a shared write enable.

---
 rtl/pipe_pkg.sv | 69 ++++++
 rtl/pipe_stage_reg_if.sv | 38 +++
 rtl/pipe_entry.sv | 58 +++++
 rtl/pipe_stage_reg.sv | 100 ++++++++++
 tb/tb_pipe_stage_reg.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and per-boundary field layouts for pipeline stage registers
//
// Holds the occupancy counter width and the control and data widths for each
// stage boundary of the five-stage core. It also holds the packed structs that
// pack and unpack the in_data/out_data buses at each boundary. In every struct
// the first field is the MSB.

package pipe_pkg;

    localparam int CNT_W = 2;

    // IF/ID boundary
    localparam int IF2ID_CTRL_W = 1;
    localparam int IF2ID_DATA_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if2id_data_t;

    // ID/EX boundary
    localparam int ID2EX_CTRL_W = 8;
    localparam int ID2EX_DATA_W = 136;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
    } id2ex_data_t;

    // EX/M boundary
    localparam int EX2M_CTRL_W = 6;
    localparam int EX2M_DATA_W = 56;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic mem_to_reg;
        logic branch;
        logic halt;
    } ex2m_ctrl_t;

    // alu_result sits in the LSBs so a small result reads directly as in_data.
    typedef struct packed {
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [15:0] store_data;
        logic [31:0] alu_result;
    } ex2m_data_t;

    // M/WB boundary
    localparam int M2WB_CTRL_W = 2;
    localparam int M2WB_DATA_W = 37;

    typedef struct packed {
        logic        reg_write;
        logic        halt;
    } m2wb_ctrl_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wb_value;
    } m2wb_data_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - handshake bundle between a pipeline stage register and its neighbours
//
// Signals:
//   in_valid/in_ready/in_ctrl/in_data     upstream beat and acceptance
//   out_valid/out_ready/out_ctrl/out_data head beat and downstream acceptance
//   flush                                 discard held and incoming beats
//   count                                 occupied entries
// Modports:
//   slave  - the stage register itself
//   master - the surrounding pipeline (or a test environment)

interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX2M_CTRL_W,
    parameter int DATA_W = EX2M_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready, flush,
        output in_ready, out_valid, out_ctrl, out_data, count
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready, flush,
        input  in_ready, out_valid, out_ctrl, out_data, count
    );
endinterface

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one storage slot of a pipeline stage register
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr               drop the slot's beat (wins over ld)
//   ld                capture ld_ctrl/ld_data and mark the slot valid
//   ld_ctrl, ld_data  beat to capture
//   valid_o           slot holds a beat
//   ctrl_o, data_o    stored beat
// Storage only changes on ld, so a cleared slot keeps its stale data.

module pipe_entry #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [DATA_W-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (ld) begin
            valid_d = 1'b1;
            ctrl_d  = ld_ctrl;
            data_d  = ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready inter-stage pipeline register with flush-to-bubble
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       pipe_stage_reg_if.slave: in_* upstream beat, out_* head beat,
//             flush, count
// Build option PIPE_SKID_EN:
//   defined   two-entry skid queue, in_ready = (count != 2) from flops only
//   undefined single entry, in_ready = !out_valid | out_ready (combinational)
// The control bits of the head are forced to zero whenever no beat is valid,
// so a bubble can never fire a downstream write or halt.

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX2M_CTRL_W,
    parameter int DATA_W = EX2M_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus
);
    logic              v0;
    logic [CTRL_W-1:0] c0;
    logic [DATA_W-1:0] d0;
    logic              ld0, clr0;
    logic [CTRL_W-1:0] src0_ctrl;
    logic [DATA_W-1:0] src0_data;
    logic              in_ready;
    logic              push, pop;
    logic [CNT_W-1:0]  cnt;

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr0),
        .ld      (ld0),
        .ld_ctrl (src0_ctrl),
        .ld_data (src0_data),
        .valid_o (v0),
        .ctrl_o  (c0),
        .data_o  (d0)
    );

`ifdef PIPE_SKID_EN
    logic              v1;
    logic [CTRL_W-1:0] c1;
    logic [DATA_W-1:0] d1;
    logic              ld1, clr1;
    logic              shift;

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr1),
        .ld      (ld1),
        .ld_ctrl (bus.in_ctrl),
        .ld_data (bus.in_data),
        .valid_o (v1),
        .ctrl_o  (c1),
        .data_o  (d1)
    );

    // Slot 1 is only ever occupied behind slot 0, so !v1 is exactly count != 2.
    always_comb begin
        in_ready  = !v1;
        push      = bus.in_valid & in_ready;
        pop       = v0 & bus.out_ready;
        shift     = pop & v1;
        // Slot 0 refills from slot 1 on a shift, otherwise from the input when
        // it is empty or its beat is leaving this cycle.
        src0_ctrl = shift ? c1 : bus.in_ctrl;
        src0_data = shift ? d1 : bus.in_data;
        ld0       = !bus.flush & (shift | (push & (!v0 | pop)));
        // The input lands in slot 1 when slot 0 stays occupied: either nothing
        // leaves, or slot 1 moves down into slot 0 on the same edge.
        ld1       = !bus.flush & push & v0 & (!pop | v1);
        clr0      = bus.flush | (pop & !v1 & !push);
        clr1      = bus.flush | (shift & !push);
        cnt       = v1 ? CNT_W'(2) : (v0 ? CNT_W'(1) : CNT_W'(0));
    end
`else
    always_comb begin
        in_ready  = !v0 | bus.out_ready;
        push      = bus.in_valid & in_ready;
        pop       = v0 & bus.out_ready;
        src0_ctrl = bus.in_ctrl;
        src0_data = bus.in_data;
        ld0       = !bus.flush & push;
        clr0      = bus.flush | (pop & !push);
        cnt       = {1'b0, v0};
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v0;
    assign bus.out_ctrl  = v0 ? c0 : '0;
    assign bus.out_data  = d0;
    assign bus.count     = cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (either PIPE_SKID_EN build)

module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = EX2M_CTRL_W;
    localparam int DW = EX2M_DATA_W;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    beat_t q[$];

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Scoreboard / occupancy model, evaluated mid-cycle on stable inputs.
    always @(negedge clk) begin
        int  exp_cnt;
        bit  exp_v, exp_rdy;
        if (rst) begin
            q.delete();
            check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
            check_eq("rst_ctrl",  64'(bus.out_ctrl),  64'd0);
            check_eq("rst_data",  64'(bus.out_data),  64'd0);
            check_eq("rst_count", 64'(bus.count),     64'd0);
            check_eq("rst_ready", 64'(bus.in_ready),  64'd1);
        end else begin
            exp_cnt = q.size();
            exp_v   = (exp_cnt != 0);
            exp_rdy = SKID ? (exp_cnt != 2) : (!exp_v || bus.out_ready);
            check_eq("count",     64'(bus.count),     64'(exp_cnt));
            check_eq("out_valid", 64'(bus.out_valid), 64'(exp_v));
            check_eq("in_ready",  64'(bus.in_ready),  64'(exp_rdy));
            if (exp_v) begin
                check_eq("head_ctrl", 64'(bus.out_ctrl), 64'(q[0].c));
                check_eq("head_data", 64'(bus.out_data), 64'(q[0].d));
                if (bus.out_ready) void'(q.pop_front());
            end else begin
                check_eq("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
            end
            if (bus.in_valid && exp_rdy) q.push_back('{c: bus.in_ctrl, d: bus.in_data});
            if (bus.flush) q.delete();
        end
    end

    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_ctrl   = c;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ex2m_data_t dat;
        ex2m_ctrl_t ctl;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Streaming 0x0001..0x0008 with out_ready held high.
        for (int i = 1; i <= 8; i++) begin
            dat = '0;
            dat.alu_result = 32'(i);
            ctl = ex2m_ctrl_t'(6'(i) ^ 6'h2A);
            step(1'b1, CW'(ctl), DW'(dat), 1'b1, 1'b0);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-pressure: out_ready low for three cycles while in_valid stays high.
        step(1'b1, 6'h01, DW'(56'h0001), 1'b0, 1'b0);
        step(1'b1, 6'h02, DW'(56'h0002), 1'b0, 1'b0);
        step(1'b1, 6'h02, DW'(56'h0002), 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush at full occupancy with a 0x3F-ctrl beat presented in the same cycle.
        step(1'b1, 6'h11, DW'(56'h11), 1'b0, 1'b0);
        step(1'b1, 6'h12, DW'(56'h12), 1'b0, 1'b0);
        step(1'b1, 6'h3F, DW'(56'h3F), 1'b0, 1'b1);
        check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
        check_eq("flush_ctrl",  64'(bus.out_ctrl),  64'd0);
        check_eq("flush_count", 64'(bus.count),     64'd0);
        repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Simultaneous push and pop at count 1.
        step(1'b1, 6'h21, DW'(56'h21), 1'b1, 1'b0);
        step(1'b1, 6'h22, DW'(56'h22), 1'b1, 1'b0);
        check_eq("pp_count", 64'(bus.count),    64'd1);
        check_eq("pp_head",  64'(bus.out_data), 64'h22);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // One-cycle out_ready stall with a valid head.
        step(1'b1, 6'h31, DW'(56'h31), 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream, observed before any clock edge.
        step(1'b1, 6'h41, DW'(56'h41), 1'b0, 1'b0);
        step(1'b1, 6'h42, DW'(56'h42), 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("arst_ctrl",  64'(bus.out_ctrl),  64'd0);
        check_eq("arst_count", 64'(bus.count),     64'd0);
        check_eq("arst_ready", 64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            step(1'b1 & ($urandom_range(0, 3) != 0), CW'($urandom), DW'({$urandom, $urandom}),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
